// File: rtl/mem_store_buffer_pkg.sv
// mem_store_buffer_pkg: shared constants, drain state and FIFO entry type for the store buffer
package mem_store_buffer_pkg;
  localparam int SB_DEPTH = 4;
  localparam int SB_ADDR_W = 8;
  localparam int SB_DATA_W = 8;
  localparam int SB_MEM_WORDS = 32;
  typedef enum logic [1:0] {IDLE, SETUP, STROBE} drain_state_t;
  typedef struct packed {
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] data;
  } sb_entry_t;
endpackage

// File: rtl/sb_fwd_match.sv
// sb_fwd_match: youngest-match search over pending store entries, oldest to youngest from head
module sb_fwd_match
  import mem_store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH
) (
  input  sb_entry_t                  entries [DEPTH],
  input  logic [$clog2(DEPTH)-1:0]   head,
  input  logic [$clog2(DEPTH):0]     count,
  input  logic [SB_ADDR_W-1:0]       addr,
  output logic                       hit,
  output logic [SB_DATA_W-1:0]       data
);
  localparam int PW = $clog2(DEPTH);
  // later (younger) matches overwrite earlier ones
  always_comb begin
    hit = 1'b0;
    data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((PW+1)'(i) < count && entries[head + PW'(i)].addr == addr) begin
        hit = 1'b1;
        data = entries[head + PW'(i)].data;
      end
    end
  end
endmodule

// File: rtl/mem_store_buffer.sv
// mem_store_buffer: store FIFO with two-cycle drain to DataMemory and forwarded one-cycle loads
module mem_store_buffer
  import mem_store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W,
  parameter int MEM_WORDS = SB_MEM_WORDS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              addr_err,
  output logic              sb_empty,
  output logic [ADDR_W-1:0] mem_Address,
  output logic [DATA_W-1:0] mem_WriteData,
  output logic              mem_MemRead,
  output logic              mem_MemWrite,
  input  logic [DATA_W-1:0] mem_ReadData
);
  localparam int PW = $clog2(DEPTH);
  sb_entry_t     fifo [DEPTH];
  sb_entry_t     head_entry;
  logic [PW-1:0] head, tail;
  logic [PW:0]   count;
  drain_state_t  state;
  logic          full, in_range, drain, load_acc, store_acc, push, pop, hit;
  logic [DATA_W-1:0] fwd_data;
  assign full = count == (PW+1)'(DEPTH);
  assign in_range = 32'(req_addr) < MEM_WORDS;
  assign drain = state != IDLE;
  assign pop = state == STROBE;
  assign req_ready = req_write ? (!full || pop) : (state == IDLE && !full);
  assign load_acc = req_valid && !req_write && req_ready;
  assign store_acc = req_valid && req_write && req_ready;
  assign push = store_acc && in_range;
  assign head_entry = fifo[head];
  assign sb_empty = count == '0 && state == IDLE;
  // strobes are gated by reset so a strobe in progress is dropped immediately
  assign mem_Address = drain ? head_entry.addr : load_acc ? req_addr : '0;
  assign mem_WriteData = drain ? head_entry.data : '0;
  assign mem_MemRead = reset && load_acc;
  assign mem_MemWrite = reset && pop;
  sb_fwd_match #(.DEPTH(DEPTH)) u_fwd (
    .entries(fifo),
    .head(head),
    .count(count),
    .addr(req_addr),
    .hit(hit),
    .data(fwd_data)
  );
  always_ff @(posedge clk) begin
    if (!reset) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      state <= IDLE;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      addr_err <= 1'b0;
    end else begin
      if (push) begin
        fifo[tail] <= {req_addr, req_wdata};
        tail <= tail + PW'(1);
      end
      if (pop) head <= head + PW'(1);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
      state <= state == IDLE ? ((count != '0 && !load_acc) ? SETUP : IDLE) :
               state == SETUP ? STROBE : IDLE;
      rsp_valid <= load_acc;
      if (load_acc) rsp_rdata <= !in_range ? '0 : hit ? fwd_data : mem_ReadData;
      addr_err <= req_valid && req_ready && !in_range;
    end
  end
endmodule

// File: doc/mem_store_buffer.md
# mem_store_buffer

Write-buffering front end for the 8-bit data memory, between the execute stage and `DataMemory`. It accepts one load or store request per cycle from the CPU and queues stores in a small FIFO. The FIFO drains to memory with a two-cycle address-setup/strobe sequence. Loads are answered one cycle later, with forwarding from pending stores, so the CPU never reads stale data.

## Interface
- `DEPTH`, 4: store FIFO entries; power of two, 2–8.
- `ADDR_W`, 8: request address width.
- `DATA_W`, 8: data width.
- `MEM_WORDS`, 32: implemented memory words; addresses ≥ `MEM_WORDS` are out of range.
- `clk` input 1: single clock; all state changes on its rising edge.
- `reset` input 1: synchronous, active-low; sampled on the rising edge of `clk`.
- `req_valid` input 1: CPU request present.
- `req_write` input 1: 1 = store, 0 = load.
- `req_addr` input `ADDR_W`: word address.
- `req_wdata` input `DATA_W`: store data.
- `req_ready` output 1: request accepted this cycle when `req_valid && req_ready`.
- `rsp_valid` output 1: load data valid; a one-cycle pulse.
- `rsp_rdata` output `DATA_W`: load data.
- `addr_err` output 1: one-cycle pulse the cycle after an accepted out-of-range request.
- `sb_empty` output 1: FIFO empty and drain FSM in IDLE; used by fences.
- `mem_Address` output `ADDR_W`: to `DataMemory.Address`.
- `mem_WriteData` output `DATA_W`: to `DataMemory.WriteData`.
- `mem_MemRead` output 1: to `DataMemory.MemRead`.
- `mem_MemWrite` output 1: to `DataMemory.MemWrite`.
- `mem_ReadData` input `DATA_W`: from `DataMemory.ReadData`; combinational.

## Operation
- **Store accept:** writes {addr, data} at the tail and increments `count`.
- **Out-of-range store:** (`req_addr >= MEM_WORDS`) is accepted and dropped, and `addr_err` is pulsed.
- **Load accept:** drives `mem_Address = req_addr` and `mem_MemRead = 1` combinationally in the accept cycle. The result is registered into `rsp_rdata`.
- **Load forwarding:** the youngest valid FIFO entry whose addr equals `req_addr` supplies the data instead of `mem_ReadData`. Entries mid-drain remain valid until popped, so they still forward.
- **Out-of-range load:** returns 0 and pulses `addr_err`.
- **Drain FSM states:**
  - IDLE → SETUP when `count > 0` and no load is accepted this cycle. A full FIFO (`count == DEPTH`) forces SETUP and blocks loads.
  - SETUP: `mem_Address` / `mem_WriteData` = head entry, `mem_MemWrite = 0`. Always → STROBE.
  - STROBE: same address and data, `mem_MemWrite = 1`. Head pops at the end of the cycle. Always → IDLE.
- **Memory-port mux:** in SETUP/STROBE the memory address is owned by the drain, so `mem_MemRead = 0`. When neither a drain nor a load is active, `mem_Address` = 0 and the strobes are 0.
- **`req_ready`:**
  - Loads: IDLE and `count < DEPTH`.
  - Stores: `count < DEPTH`, or state == STROBE (pop and push in the same cycle).
- **Simultaneous push and pop:** `count` unchanged. Pointers wrap modulo `DEPTH`.
- **`count` width:** `$clog2(DEPTH)+1`; it never exceeds `DEPTH`.

## Timing
- Load latency is 1 cycle: accepted at edge N, `rsp_valid`/`rsp_rdata` valid after edge N+1 for exactly one cycle.
- A store reaches memory after at least 2 cycles: SETUP then STROBE. The strobe rises one full cycle after the address settles and falls when the entry pops.
- Back-to-back drains: IDLE separates each SETUP/STROBE pair, giving 3 cycles per store minimum. Loads can win the IDLE cycle unless the FIFO is full.
- **Reset** (when `reset == 0` at an edge), all of the following are cleared:
  - FIFO: `count`, head, tail = 0.
  - FSM = IDLE.
  - `rsp_valid` = 0, `rsp_rdata` = 0, `addr_err` = 0, `sb_empty` = 1.
  - Memory strobes = 0.
- Reset mid-drain abandons pending stores; a STROBE in progress drops `mem_MemWrite` in the same cycle. The contents of `DataMemory` are untouched.

## Structure
- Package `mem_store_buffer_pkg` holds:
  - the drain state enum (IDLE, SETUP, STROBE);
  - the default width and depth constants;
  - the FIFO entry struct {addr, data}.
- Sub-module `sb_fwd_match`: combinational youngest-match search over the FIFO entries. It returns hit and data, using head/count to order age.

## Test plan
- Reset, then load addr 5 with the FIFO empty → next cycle `rsp_valid = 1`, `rsp_rdata = 8'd5` (memory preset), `sb_empty = 1`.
- Store 3←0xAA, then load 3 on the next cycle → `rsp_rdata = 0xAA` via forwarding; memory later sees `mem_MemWrite` high for exactly 1 cycle, with `mem_Address = 3` held from the SETUP cycle.
- Stores 7←0x11 then 7←0x22, load 7 before the drain → 0x22. After `sb_empty` rises, a load of 7 → 0x22 from memory.
- Fill 4 stores back to back → `req_ready = 0` for a store and a load at `count == 4`. A fifth store is accepted in the STROBE cycle and `count` stays 4.
- Store to addr 40 → `addr_err` pulses, `count` unchanged, no `mem_MemWrite`. Load addr 40 → `rsp_rdata = 0`, `addr_err = 1`.
- Assert `reset = 0` during STROBE with 3 entries pending → next cycle `mem_MemWrite = 0`, `count = 0`, FSM IDLE, `sb_empty = 1`.
